vec_mac_sched: RTL and testbench

Round-robin scheduler that shares one vector MAC engine (vec_mul) among N_REQ requesters. It accepts one operand-vector pair per job over a valid/ready handshake and latches the operands. It drives the engine's enable, waits for its valid pulse, and returns the truncated result to the owning requester. A watchdog aborts jobs whose engine never signals valid.

---
 rtl/vec_mac_sched_if.sv | 32 +++
 rtl/vec_mac_sched.sv | 112 +++++++++++
 tb/tb_vec_mac_sched.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/vec_mac_sched_if.sv
// rtl/vec_mac_sched_if.sv - requester, response and engine signal bundle for vec_mac_sched
interface vec_mac_sched_if #(
  parameter int N_REQ = 4,
  parameter int C     = 8,
  parameter int W_X   = 8,
  parameter int W_K   = 8
);
  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ-1:0]                 req_ready;
  logic [N_REQ-1:0][C-1:0][W_K-1:0] req_k;
  logic [N_REQ-1:0][C-1:0][W_X-1:0] req_x;
  logic [N_REQ-1:0]                 rsp_valid;
  logic [N_REQ-1:0]                 rsp_ready;
  logic [W_X-1:0]                   rsp_y;
  logic                             rsp_err;
  logic                             mac_enable;
  logic [C-1:0][W_K-1:0]            mac_k;
  logic [C-1:0][W_X-1:0]            mac_x;
  logic [W_X-1:0]                   mac_y;
  logic                             mac_valid;
  logic                             busy;

  // slave: the scheduler; master: requesters plus the MAC engine
  modport slave (
    input  req_valid, req_k, req_x, rsp_ready, mac_y, mac_valid,
    output req_ready, rsp_valid, rsp_y, rsp_err, mac_enable, mac_k, mac_x, busy
  );
  modport master (
    output req_valid, req_k, req_x, rsp_ready, mac_y, mac_valid,
    input  req_ready, rsp_valid, rsp_y, rsp_err, mac_enable, mac_k, mac_x, busy
  );
endinterface

// File: rtl/vec_mac_sched.sv
// rtl/vec_mac_sched.sv - round-robin scheduler sharing one vector MAC engine among requesters
module vec_mac_sched #(
  parameter int N_REQ   = 4,
  parameter int C       = 8,
  parameter int W_X     = 8,
  parameter int W_K     = 8,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rstn,
  vec_mac_sched_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]            r_state;
  logic [PW-1:0]         r_prio;
  logic [PW-1:0]         r_owner;
  logic [CW-1:0]         r_cnt;
  logic [W_X-1:0]        r_y;
  logic                  r_err;
  logic [C-1:0][W_K-1:0] r_k;
  logic [C-1:0][W_X-1:0] r_x;

  logic                  w_found;
  logic [PW-1:0]         w_grant;
  logic [PW-1:0]         w_idx;
  int                    w_t;

  // first valid requester at or after r_prio, wrapping past N_REQ-1
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    w_t     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_t = int'(r_prio) + i;
      if (w_t >= N_REQ) w_t = w_t - N_REQ;
      w_idx = PW'(w_t);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (r_state == S_IDLE && w_found) bus.req_ready[w_grant] = 1'b1;
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (r_state == S_RESP) bus.rsp_valid[r_owner] = 1'b1;
  end

  assign bus.mac_enable = (r_state == S_RUN);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.rsp_y      = r_y;
  assign bus.rsp_err    = r_err;
  assign bus.mac_k      = r_k;
  assign bus.mac_x      = r_x;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_prio  <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_err   <= 1'b0;
      r_k     <= '0;
      r_x     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_k     <= bus.req_k[w_grant];
            r_x     <= bus.req_x[w_grant];
            r_owner <= w_grant;
            r_prio  <= (w_grant == PW'(N_REQ - 1)) ? '0 : w_grant + 1'b1;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // an engine result on the last watchdog cycle still counts as success
          if (bus.mac_valid) begin
            r_y     <= bus.mac_y;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_y     <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready[r_owner]) r_state <= S_DRAIN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_mac_sched.sv
// tb/tb_vec_mac_sched.sv - self-checking bench for vec_mac_sched with a latency-programmable engine model
module tb_vec_mac_sched;
  localparam int N_REQ   = 4;
  localparam int C       = 8;
  localparam int W_X     = 8;
  localparam int W_K     = 8;
  localparam int TIMEOUT = 64;

  typedef logic [C-1:0][W_K-1:0] kvec_t;
  typedef logic [C-1:0][W_X-1:0] xvec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  vec_mac_sched_if #(.N_REQ(N_REQ), .C(C), .W_X(W_X), .W_K(W_K)) bus ();

  vec_mac_sched #(.N_REQ(N_REQ), .C(C), .W_X(W_X), .W_K(W_K), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int eng_lat = 3;
  int e_cnt   = 0;
  int m_ptr   = 0;

  function automatic logic [W_X-1:0] dot(kvec_t k, xvec_t x);
    int s = 0;
    for (int i = 0; i < C; i++) s += $signed(k[i]) * $signed(x[i]);
    return W_X'(s);
  endfunction

  // engine: result strobe after eng_lat enabled cycles; enable low clears it
  always @(posedge clk) e_cnt <= bus.mac_enable ? e_cnt + 1 : 0;
  assign bus.mac_valid = bus.mac_enable && (e_cnt == eng_lat);
  assign bus.mac_y     = dot(bus.mac_k, bus.mac_x);

  task automatic check_eq(string tag, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_grant(logic [N_REQ-1:0] mask);
    for (int i = 0; i < N_REQ; i++)
      if (mask[(m_ptr + i) % N_REQ]) return (m_ptr + i) % N_REQ;
    return 0;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(int g);
    return N_REQ'(1) << g;
  endfunction

  task automatic scramble();
    for (int r = 0; r < N_REQ; r++)
      for (int i = 0; i < C; i++) begin
        bus.req_k[r][i] = W_K'($urandom);
        bus.req_x[r][i] = W_X'($urandom);
      end
  endtask

  task automatic start_job(input logic [N_REQ-1:0] mask, input bit keep,
                           output int g, output logic [W_X-1:0] ey);
    bus.req_valid = mask;
    #1;
    g  = ref_grant(mask);
    ey = dot(bus.req_k[g], bus.req_x[g]);
    check_eq("req_ready_grant", int'(bus.req_ready), int'(onehot(g)));
    tick();
    m_ptr = (g + 1) % N_REQ;
    if (!keep) bus.req_valid = '0;
    scramble();
    check_eq("run_busy", int'(bus.busy), 1);
    check_eq("run_mac_enable", int'(bus.mac_enable), 1);
  endtask

  task automatic finish_job(input int g, input logic [W_X-1:0] ey, input bit eerr, input int bp);
    int cyc = 0;
    int exp_cyc = (eng_lat >= TIMEOUT) ? TIMEOUT : eng_lat + 1;
    while (bus.rsp_valid == '0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq("resp_latency", cyc, exp_cyc);
    for (int b = 0; b <= bp; b++) begin
      check_eq("rsp_valid", int'(bus.rsp_valid), int'(onehot(g)));
      check_eq("rsp_y", int'(bus.rsp_y), int'(ey));
      check_eq("rsp_err", int'(bus.rsp_err), int'(eerr));
      check_eq("resp_mac_enable", int'(bus.mac_enable), 0);
      check_eq("resp_req_ready", int'(bus.req_ready), 0);
      if (b == bp) bus.rsp_ready = onehot(g) | N_REQ'($urandom);
      else         bus.rsp_ready = N_REQ'($urandom) & ~onehot(g);
      tick();
    end
    bus.rsp_ready = '0;
    check_eq("drain_rsp_valid", int'(bus.rsp_valid), 0);
    check_eq("drain_busy", int'(bus.busy), 1);
    check_eq("drain_req_ready", int'(bus.req_ready), 0);
    check_eq("drain_mac_enable", int'(bus.mac_enable), 0);
    tick();
    check_eq("idle_busy", int'(bus.busy), 0);
  endtask

  task automatic check_reset_state(string tag);
    check_eq({tag, "_busy"}, int'(bus.busy), 0);
    check_eq({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
    check_eq({tag, "_req_ready"}, int'(bus.req_ready), 0);
    check_eq({tag, "_mac_enable"}, int'(bus.mac_enable), 0);
    check_eq({tag, "_rsp_y"}, int'(bus.rsp_y), 0);
    check_eq({tag, "_rsp_err"}, int'(bus.rsp_err), 0);
    check_eq({tag, "_mac_kx"}, int'(bus.mac_k == '0 && bus.mac_x == '0), 1);
  endtask

  task automatic pulse_reset(string tag);
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    rstn = 1'b0;
    tick();
    check_reset_state(tag);
    rstn = 1'b1;
    m_ptr = 0;
  endtask

  int                 g;
  logic [W_X-1:0]     ey;
  kvec_t              kv;
  xvec_t              xv;
  int                 order[8];
  logic [N_REQ-1:0]   mask;

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_k     = '0;
    bus.req_x     = '0;
    repeat (3) tick();
    check_reset_state("reset");
    rstn = 1'b1;
    tick();

    // directed dot products: 36, overflow to 0, and -36
    for (int i = 0; i < C; i++) begin kv[i] = 8'd1; xv[i] = W_X'(i + 1); end
    bus.req_k[0] = kv; bus.req_x[0] = xv;
    start_job(4'b0001, 1'b0, g, ey);
    finish_job(g, 8'd36, 1'b0, 0);
    for (int i = 0; i < C; i++) begin kv[i] = 8'd16; xv[i] = 8'd16; end
    bus.req_k[0] = kv; bus.req_x[0] = xv;
    start_job(4'b0001, 1'b0, g, ey);
    finish_job(g, 8'h00, 1'b0, 0);
    for (int i = 0; i < C; i++) begin kv[i] = 8'hFF; xv[i] = W_X'(i + 1); end
    bus.req_k[0] = kv; bus.req_x[0] = xv;
    start_job(4'b0001, 1'b0, g, ey);
    finish_job(g, 8'hDC, 1'b0, 0);

    // round-robin with all requests held, then requester 1 dropped for one grant
    pulse_reset("rr_reset");
    order = '{0, 1, 2, 3, 0, 2, 3, 0};
    for (int j = 0; j < 8; j++) begin
      mask = (j == 5) ? 4'b1101 : 4'b1111;
      start_job(mask, 1'b1, g, ey);
      check_eq("rr_order", g, order[j]);
      finish_job(g, ey, 1'b0, 0);
    end
    start_job(4'b1111, 1'b1, g, ey);
    check_eq("rr_order_last", g, 1);
    finish_job(g, ey, 1'b0, 0);

    // backpressure for 10 cycles with other requesters waiting
    start_job(4'b1111, 1'b1, g, ey);
    finish_job(g, ey, 1'b0, 10);

    // watchdog abort, then a result on the final watchdog cycle
    eng_lat = 1000;
    start_job(4'b0010, 1'b0, g, ey);
    finish_job(g, 8'h00, 1'b1, 2);
    eng_lat = TIMEOUT - 1;
    start_job(4'b1000, 1'b0, g, ey);
    finish_job(g, ey, 1'b0, 0);
    eng_lat = 3;

    // reset mid-RUN, then a clean job from requester 2
    start_job(4'b0001, 1'b0, g, ey);
    tick();
    pulse_reset("rst_run");
    start_job(4'b0100, 1'b0, g, ey);
    finish_job(g, ey, 1'b0, 0);

    // reset mid-RESP, then all requesting must grant requester 0 again
    start_job(4'b1000, 1'b0, g, ey);
    for (int c = 0; c < 20 && bus.rsp_valid == '0; c++) tick();
    check_eq("rst_resp_reached", int'(bus.rsp_valid), int'(onehot(3)));
    pulse_reset("rst_resp");
    start_job(4'b1111, 1'b0, g, ey);
    check_eq("ptr_after_reset", g, 0);
    finish_job(g, ey, 1'b0, 0);

    // randomized jobs
    for (int j = 0; j < 30; j++) begin
      scramble();
      eng_lat = int'($urandom_range(1, 5));
      mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      start_job(mask, 1'($urandom), g, ey);
      finish_job(g, ey, 1'b0, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
